edu_rtl: RTL and testbench
==========================

// Module: edu_rtl
// PURPOSE
// - Error detection/correction unit (EDU) at the input of each router's path-computation stage.
// - Receives one 11-bit flit over a 4-phase bundled-data handshake:
//   flit[10:4] = 7-bit Hamming(7,4) codeword, flit[3:0] = destination address.
// - Corrects any single-bit codeword error.
// - Forwards the flit on a second 4-phase bundled-data handshake to the address/route decoder.
// PARAMETERS
// - WIDTH        11  flit width (fixed layout: [10:4] codeword, [3:0] address)
// - SYNC_STAGES  2   flops in each req/ack input synchronizer (min 2)
// - ECC_EN       1   1 = correct codeword; 0 = pass flit through unchanged
// PORTS
// - CLK          in   1      single clock, rising edge
// - _RESET       in   1      asynchronous, active-low reset
// - in_req       in   1      upstream request (4-phase)
// - in_data      in   WIDTH  upstream flit; stable while in_req=1
// - in_ack       out  1      upstream acknowledge
// - out_req      out  1      downstream request (4-phase)
// - out_data     out  WIDTH  corrected flit; stable while out_req=1 and until out_ack returns to 0
// - out_ack      in   1      downstream acknowledge
// - err_detect   out  1      1 = last accepted flit had nonzero syndrome; held until next accept
// BEHAVIOUR
// - Reset (_RESET=0, async): in_ack=0, out_req=0, out_data=0, err_detect=0, synchronizers=0, state=IDLE.
// - Reset mid-handshake aborts immediately; the flit is dropped.
// - in_req and out_ack each pass through a SYNC_STAGES-flop synchronizer. The FSM sees only the synced values.
// - ECC on codeword c = flit[10:4], with c[i] = Hamming position i+1:
//   - P1 = c0^c2^c4^c6
//   - P2 = c1^c2^c5^c6
//   - P4 = c3^c4^c5^c6
//   - syndrome = {P4,P2,P1}
//   - syndrome 0: no change. Syndrome s in 1..7: invert c[s-1].
//   - Address bits [3:0] are never modified.
//   - Double errors are miscorrected; no 2-bit detection.
// - FSM states and transitions:
//   - IDLE: on synced in_req=1, register the corrected flit into out_data and the syndrome!=0 flag into err_detect. Set in_ack=1 and go to IN_ACK.
//   - IN_ACK: on synced in_req=0, set in_ack=0, set out_req=1, go to OUT_REQ.
//   - OUT_REQ: on synced out_ack=1, set out_req=0, go to OUT_REL.
//   - OUT_REL: on synced out_ack=0, go to IDLE.
// - Latency:
//   - in_ack rises on the (SYNC_STAGES+1)th rising CLK edge after in_req rises.
//   - out_req rises SYNC_STAGES+1 edges after in_req falls.
// - Exactly one flit is in flight; no new input is accepted until OUT_REL completes.
// - out_data changes only on the IDLE->IN_ACK edge.
// - in_req asserted while busy: held off; upstream waits.
// - Registered outputs only; no combinational path from any input to any output.
// TESTING
// - Reset: hold _RESET=0 with in_req=1 -> in_ack=0, out_req=0, out_data=0. After release, normal accept.
// - Clean flit: in_data=11'h7F3 -> out_data=11'h7F3, err_detect=0; full 4-phase sequence on both sides.
// - Single error at c[2]: in_data=11'h045 (syndrome 3) -> out_data=11'h005, err_detect=1.
// - Single error at c[0]: in_data=11'h7EA (syndrome 1) -> out_data=11'h7FA, err_detect=1.
// - Double error: in_data=11'h031 (syndrome 3) -> out_data=11'h071 (miscorrection by design).
// - Back-pressure: hold out_ack=0 for 50 cycles while in_req re-asserts with 11'h0F0.
//   -> out_req and out_data stay stable; second flit acked only after OUT_REL.
// - ECC_EN=0: in_data=11'h045 -> out_data=11'h045.
// - Reset pulse asserted in OUT_REQ -> out_req drops asynchronously; FSM returns to IDLE.

Source files
------------

// File: rtl/edu_rtl.sv
// ---------------------------------------------------------------------------
// edu_rtl -- error detection/correction unit at the input of a router's
// path-computation stage.
//
// A flit arrives on a 4-phase bundled-data handshake (in_req/in_ack). Its
// upper seven bits are a Hamming(7,4) codeword and its lower four bits are a
// destination address. Any single-bit error in the codeword is corrected,
// the address is passed untouched, and the flit is offered downstream on a
// second 4-phase handshake (out_req/out_ack). Exactly one flit is held at a
// time.
//
// Parameters
//   WIDTH        flit width (layout fixed: [10:4] codeword, [3:0] address)
//   SYNC_STAGES  flops in each req/ack input synchronizer (2 or more)
//   ECC_EN       1 = correct the codeword, 0 = forward the flit unchanged
//
// Ports
//   CLK         in   rising-edge clock
//   _RESET      in   asynchronous active-low reset
//   in_req      in   upstream request (4-phase)
//   in_data     in   upstream flit, stable while in_req is high
//   in_ack      out  upstream acknowledge
//   out_req     out  downstream request (4-phase)
//   out_data    out  corrected flit, stable through the downstream handshake
//   out_ack     in   downstream acknowledge
//   err_detect  out  last accepted flit had a nonzero syndrome
// ---------------------------------------------------------------------------
module edu_rtl #(
  parameter int WIDTH       = 11,
  parameter int SYNC_STAGES = 2,
  parameter bit ECC_EN      = 1'b1
) (
  input  logic             CLK,
  input  logic             _RESET,
  input  logic             in_req,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ack,
  output logic             out_req,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ack,
  output logic             err_detect
);

  localparam int CW_LSB = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IN_ACK  = 2'd1,
    OUT_REQ = 2'd2,
    OUT_REL = 2'd3
  } state_t;

  // Syndrome bit k is the parity over every codeword position whose 1-based
  // index has bit k set, so a nonzero syndrome names the flipped position.
  function automatic logic [2:0] hamming_syndrome(input logic [6:0] c);
    logic p1;
    logic p2;
    logic p4;
    p1 = c[0] ^ c[2] ^ c[4] ^ c[6];
    p2 = c[1] ^ c[2] ^ c[5] ^ c[6];
    p4 = c[3] ^ c[4] ^ c[5] ^ c[6];
    return {p4, p2, p1};
  endfunction

  // Flip the position named by the syndrome. A double error yields the
  // syndrome of some third position, which then gets flipped as well; no
  // attempt is made to detect that case.
  function automatic logic [6:0] hamming_correct(input logic [6:0] c,
                                                 input logic [2:0] s);
    logic [6:0] fix;
    fix = c;
    if (s != 3'd0) begin
      fix[s - 3'd1] = ~fix[s - 3'd1];
    end
    return fix;
  endfunction

  // ------------------------------------------------------------------
  // Handshake input synchronizers. in_data is bundled with in_req and is
  // only sampled once the synchronized request is seen, so it needs none.
  // ------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] req_sync_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   req_seen;
  logic                   ack_seen;

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      req_sync_q <= '0;
      ack_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], in_req};
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], out_ack};
    end
  end

  assign req_seen = req_sync_q[SYNC_STAGES-1];
  assign ack_seen = ack_sync_q[SYNC_STAGES-1];

  // ------------------------------------------------------------------
  // Stage p0: syndrome and correction of the incoming flit (combinational,
  // captured into out_data only when the flit is accepted).
  // ------------------------------------------------------------------
  logic [6:0]       cw_p0;
  logic [2:0]       syn_p0;
  logic             syn_nz_p0;
  logic [WIDTH-1:0] flit_fix_p0;

  assign cw_p0     = in_data[WIDTH-1:CW_LSB];
  assign syn_p0    = hamming_syndrome(cw_p0);
  assign syn_nz_p0 = (syn_p0 != 3'd0);

  always_comb begin
    flit_fix_p0 = in_data;
    if (ECC_EN) begin
      flit_fix_p0[WIDTH-1:CW_LSB] = hamming_correct(cw_p0, syn_p0);
    end
  end

  // ------------------------------------------------------------------
  // Stage p1: handshake FSM and registered outputs.
  // ------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  logic   in_ack_d;
  logic   out_req_d;
  logic   load_flit;

  always_comb begin
    state_d   = state_q;
    in_ack_d  = in_ack;
    out_req_d = out_req;
    load_flit = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_seen) begin
          load_flit = 1'b1;
          in_ack_d  = 1'b1;
          state_d   = IN_ACK;
        end
      end
      IN_ACK: begin
        if (!req_seen) begin
          in_ack_d  = 1'b0;
          out_req_d = 1'b1;
          state_d   = OUT_REQ;
        end
      end
      OUT_REQ: begin
        if (ack_seen) begin
          out_req_d = 1'b0;
          state_d   = OUT_REL;
        end
      end
      OUT_REL: begin
        // A request that arrived while busy is only honoured from IDLE.
        if (!ack_seen) begin
          state_d = IDLE;
        end
      end
      default: begin
        in_ack_d  = 1'b0;
        out_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state_q <= IDLE;
      in_ack  <= 1'b0;
      out_req <= 1'b0;
    end else begin
      state_q <= state_d;
      in_ack  <= in_ack_d;
      out_req <= out_req_d;
    end
  end

  // out_data is reset so a downstream observer never sees an undefined
  // flit; it otherwise moves only when a new flit is accepted.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      out_data   <= '0;
      err_detect <= 1'b0;
    end else if (load_flit) begin
      out_data   <= flit_fix_p0;
      err_detect <= syn_nz_p0;
    end
  end

endmodule

// File: tb/tb_edu_rtl.sv
module tb_edu_rtl;

  localparam int W = 11;
  localparam int S = 2;

  logic         CLK      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         in_req   = 1'b0;
  logic [W-1:0] in_data  = '0;
  logic         out_ack  = 1'b0;
  logic         in_ack, out_req, err_detect;
  logic [W-1:0] out_data;
  logic         in_ack_r, out_req_r, err_detect_r;
  logic [W-1:0] out_data_r;

  int checks   = 0;
  int failures = 0;
  bit hold_ack = 1'b0;

  always #5 CLK = ~CLK;

  edu_rtl #(.WIDTH(W), .SYNC_STAGES(S), .ECC_EN(1'b1)) dut (
    .CLK(CLK), ._RESET(rst_n),
    .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
    .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
    .err_detect(err_detect)
  );

  edu_rtl #(.WIDTH(W), .SYNC_STAGES(S), .ECC_EN(1'b0)) dut_raw (
    .CLK(CLK), ._RESET(rst_n),
    .in_req(in_req), .in_data(in_data), .in_ack(in_ack_r),
    .out_req(out_req_r), .out_data(out_data_r), .out_ack(out_ack),
    .err_detect(err_detect_r)
  );

  // ---------------- reference model ----------------
  // Syndrome = XOR of the 1-based positions of all set codeword bits.
  function automatic int ref_syn(input logic [W-1:0] f);
    int s;
    s = 0;
    for (int i = 0; i < 7; i++) if (f[4+i]) s = s ^ (i + 1);
    return s;
  endfunction

  function automatic logic [W-1:0] ref_fix(input logic [W-1:0] f);
    logic [W-1:0] r;
    int s;
    r = f;
    s = ref_syn(f);
    if (s != 0) r[4+s-1] = ~r[4+s-1];
    return r;
  endfunction

  // Handshake phases: 0 waiting for a flit, 1 acknowledging upstream,
  // 2 offering downstream, 3 waiting for downstream release.
  // The block reacts to inputs as they looked S clock edges earlier.
  int           m_phase = 0;
  bit           m_in_ack = 0, m_out_req = 0, m_err = 0;
  logic [W-1:0] m_data = '0, m_raw = '0;
  bit           rq_h[S];
  bit           ak_h[S];

  initial begin
    bit sr, sa;
    for (int i = 0; i < S; i++) begin rq_h[i] = 0; ak_h[i] = 0; end
    forever begin
      @(posedge CLK or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_in_ack = 0; m_out_req = 0; m_err = 0;
        m_data = '0; m_raw = '0;
        for (int i = 0; i < S; i++) begin rq_h[i] = 0; ak_h[i] = 0; end
      end else begin
        sr = rq_h[S-1];
        sa = ak_h[S-1];
        if (m_phase == 0 && sr) begin
          m_data = ref_fix(in_data); m_raw = in_data;
          m_err = (ref_syn(in_data) != 0); m_in_ack = 1; m_phase = 1;
        end else if (m_phase == 1 && !sr) begin
          m_in_ack = 0; m_out_req = 1; m_phase = 2;
        end else if (m_phase == 2 && sa) begin
          m_out_req = 0; m_phase = 3;
        end else if (m_phase == 3 && !sa) begin
          m_phase = 0;
        end
        for (int i = S - 1; i > 0; i--) begin rq_h[i] = rq_h[i-1]; ak_h[i] = ak_h[i-1]; end
        rq_h[0] = in_req;
        ak_h[0] = out_ack;
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge CLK);
      chk("mdl_in_ack",      in_ack,     m_in_ack);
      chk("mdl_out_req",     out_req,    m_out_req);
      chk("mdl_out_data",    out_data,   m_data);
      chk("mdl_err_detect",  err_detect, m_err);
      chk("mdl_raw_in_ack",  in_ack_r,   m_in_ack);
      chk("mdl_raw_out_req", out_req_r,  m_out_req);
      chk("mdl_raw_data",    out_data_r, m_raw);
    end
  end

  // Downstream responder with random acknowledge/release delays.
  initial begin
    forever begin
      @(negedge CLK);
      if (!hold_ack && out_req && !out_ack) begin
        repeat ($urandom_range(0, 4)) @(negedge CLK);
        out_ack = 1'b1;
      end else if (out_ack && !out_req) begin
        repeat ($urandom_range(0, 4)) @(negedge CLK);
        out_ack = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic sig(input int sel);
    case (sel)
      0:       return in_ack;
      1:       return out_req;
      default: return out_ack;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input string nm);
    int n;
    n = 0;
    while (sig(sel) !== val && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk(nm, sig(sel), val);
  endtask

  task automatic go_idle();
    wait_sig(1, 1'b0, "idle_out_req");
    wait_sig(2, 1'b0, "idle_out_ack");
    repeat (S + 3) @(negedge CLK);
  endtask

  // Directed transfer with latency checks on both handshakes.
  task automatic xfer(input logic [W-1:0] d, input logic [W-1:0] fix,
                      input logic e, input logic [W-1:0] raw);
    go_idle();
    in_data = d;
    in_req  = 1'b1;
    repeat (S) begin @(negedge CLK); chk("in_ack_lat_low", in_ack, 1'b0); end
    @(negedge CLK); chk("in_ack_lat_high", in_ack, 1'b1);
    in_req = 1'b0;
    repeat (S) begin @(negedge CLK); chk("out_req_lat_low", out_req, 1'b0); end
    @(negedge CLK); chk("out_req_lat_high", out_req, 1'b1);
    chk("lit_out_data", out_data, fix);
    chk("lit_err", err_detect, e);
    chk("lit_raw_data", out_data_r, raw);
  endtask

  task automatic send(input logic [W-1:0] d);
    wait_sig(0, 1'b0, "send_in_ack_low");
    in_data = d;
    in_req  = 1'b1;
    wait_sig(0, 1'b1, "send_in_ack_high");
    in_req = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] d;

    // Reset held with a request pending.
    in_req  = 1'b1;
    in_data = 11'h7F3;
    repeat (5) @(negedge CLK);
    chk("rst_in_ack", in_ack, 1'b0);
    chk("rst_out_req", out_req, 1'b0);
    chk("rst_out_data", out_data, 11'h000);
    chk("rst_err", err_detect, 1'b0);
    rst_n = 1'b1;
    wait_sig(0, 1'b1, "post_rst_accept");
    in_req = 1'b0;
    wait_sig(1, 1'b1, "post_rst_out_req");
    chk("clean_out_data", out_data, 11'h7F3);
    chk("clean_err", err_detect, 1'b0);

    // Directed codewords.
    xfer(11'h7F3, 11'h7F3, 1'b0, 11'h7F3);
    xfer(11'h045, 11'h005, 1'b1, 11'h045);
    xfer(11'h7EA, 11'h7FA, 1'b1, 11'h7EA);
    xfer(11'h031, 11'h071, 1'b1, 11'h031);

    // Back-pressure: downstream stalls while a new request waits.
    go_idle();
    hold_ack = 1'b1;
    send(11'h7EA);
    wait_sig(1, 1'b1, "bp_out_req");
    in_data = 11'h0F0;
    in_req  = 1'b1;
    repeat (50) begin
      @(negedge CLK);
      chk("bp_out_req_hold", out_req, 1'b1);
      chk("bp_out_data_hold", out_data, 11'h7FA);
      chk("bp_in_ack_held_off", in_ack, 1'b0);
    end
    hold_ack = 1'b0;
    wait_sig(0, 1'b1, "bp_second_accept");
    chk("bp_second_data", out_data, 11'h070);
    chk("bp_second_err", err_detect, 1'b1);
    in_req = 1'b0;

    // Reset while offering downstream.
    go_idle();
    hold_ack = 1'b1;
    send(11'h031);
    wait_sig(1, 1'b1, "mid_out_req");
    chk("mid_data", out_data, 11'h071);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_req", out_req, 1'b0);
    chk("async_in_ack", in_ack, 1'b0);
    chk("async_out_data", out_data, 11'h000);
    @(negedge CLK);
    rst_n    = 1'b1;
    hold_ack = 1'b0;
    xfer(11'h7EA, 11'h7FA, 1'b1, 11'h7EA);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      d = W'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      send(d);
    end
    go_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
